shift_arbiter_64: RTL

Shares the existing single 64-bit combinational shifter between two requesters (port 0: integer ALU issue, port 1: secondary unit such as address/CSR logic) with round-robin arbitration. Each requester uses a valid/ready handshake; the winning operation is shifted in the acceptance cycle and its result is held in a one-entry registered output slot, tagged with requester id and a caller tag. The block sits between issue logic and writeback as the only client of the shifter.

---
 rtl/shift_arbiter_64_pkg.sv | 14 +
 rtl/shift_arbiter_64_rr_arb2.sv | 39 +++
 rtl/shift_arbiter_64.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shift_arbiter_64_pkg.sv
// Shared widths and slot state encoding for the shift arbiter.
// Word-op support is compiled in with SHIFT_WORD_OP_EN.
package shift_arbiter_64_pkg;

    localparam int SHIFT_W      = 64;
    localparam int SHAMT_W      = 6;
    localparam int WORD_SHAMT_W = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/shift_arbiter_64_rr_arb2.sv
// Two-way round-robin grant with last-grant memory.
// last_grant only moves on an accepted transfer.
module shift_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic slot_avail,
    output logic ready0,
    output logic ready1,
    output logic grant,
    output logic accept
);

    logic last_grant;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            valid0 & valid1:  grant = ~last_grant;
            valid1 & ~valid0: grant = 1'b1;
            default:          grant = 1'b0;
        endcase
    end

    assign ready0 = ~rst & slot_avail & ~grant;
    assign ready1 = ~rst & slot_avail & grant;
    assign accept = (valid0 & ready0) | (valid1 & ready1);

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/shift_arbiter_64.sv
// Shares one 64-bit shifter between two requesters, registered result slot.
// Define SHIFT_WORD_OP_EN to honour the RV64 W-op request bit.
module shift_arbiter_64
    import shift_arbiter_64_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [63:0]        req0_data,
    input  logic [5:0]         req0_shamt,
    input  logic               req0_right,
    input  logic               req0_sra,
    input  logic               req0_word,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [63:0]        req1_data,
    input  logic [5:0]         req1_shamt,
    input  logic               req1_right,
    input  logic               req1_sra,
    input  logic               req1_word,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_data,
    output logic               rsp_id,
    output logic [TAG_W-1:0]   rsp_tag
);

    slot_state_e state, state_nx;
    logic grant, accept, slot_avail;

    assign slot_avail = (state == SLOT_EMPTY) | rsp_ready;
    assign rsp_valid  = (state == SLOT_FULL);

    shift_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .slot_avail (slot_avail),
        .ready0     (req0_ready),
        .ready1     (req1_ready),
        .grant      (grant),
        .accept     (accept)
    );

    logic [SHIFT_W-1:0] s_data;
    logic [SHAMT_W-1:0] s_shamt;
    logic               s_right, s_sra;
    logic [TAG_W-1:0]   s_tag;

    assign s_data  = grant ? req1_data  : req0_data;
    assign s_shamt = grant ? req1_shamt : req0_shamt;
    assign s_right = grant ? req1_right : req0_right;
    assign s_sra   = grant ? req1_sra   : req0_sra;
    assign s_tag   = grant ? req1_tag   : req0_tag;

`ifdef SHIFT_WORD_OP_EN
    logic s_word;
    assign s_word = grant ? req1_word : req0_word;
`else
    logic unused_word;
    assign unused_word = req0_word ^ req1_word;
`endif

    logic [SHIFT_W-1:0] op, raw, res;
    logic [SHAMT_W-1:0] amt;

    always_comb begin
        op  = s_data;
        amt = s_shamt;
        raw = '0;
`ifdef SHIFT_WORD_OP_EN
        if (s_word) begin
            amt = {1'b0, s_shamt[WORD_SHAMT_W-1:0]};
            if (s_right) begin
                op = {{32{s_sra & s_data[31]}}, s_data[31:0]};
            end
        end
`endif
        if (!s_right) begin
            raw = op << amt;
        end else if (s_sra) begin
            raw = $signed(op) >>> amt;
        end else begin
            raw = op >> amt;
        end
        res = raw;
`ifdef SHIFT_WORD_OP_EN
        if (s_word) begin
            res = {{32{raw[31]}}, raw[31:0]};
        end
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SLOT_EMPTY: if (accept) state_nx = SLOT_FULL;
            SLOT_FULL: begin
                if (accept) begin
                    state_nx = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_nx = SLOT_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SLOT_EMPTY;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rsp_tag  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rsp_data <= res;
                rsp_id   <= grant;
                rsp_tag  <= s_tag;
            end
        end
    end

endmodule
